// File: rtl/fir_sample_tx.sv
// Sample transmitter for the 8-tap FIR: FIFO-buffered stream, gapped VIN/DIN strobes,
// zero-sample flush, coefficient bank. Optional underrun counter: FIR_TX_UNDERRUN_CNT_EN.
module fir_sample_tx #(
   parameter int DW    = 13,
   parameter int DEPTH = 8,
   parameter int NTAPS = 8
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  S_VALID,
   input  logic [DW-1:0]         S_DATA,
   input  logic                  S_LAST,
   output logic                  S_READY,
   input  logic                  START,
   input  logic [3:0]            GAP,
   input  logic                  COEF_WE,
   input  logic [2:0]            COEF_ADDR,
   input  logic [DW-1:0]         COEF_WDATA,
   output logic [NTAPS*DW-1:0]   H_FLAT,
   output logic                  VIN,
   output logic [DW-1:0]         DIN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [15:0]           SAMPLE_CNT
`ifdef FIR_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]           UNDERRUN_CNT
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(NTAPS) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_FLUSH} state_t;

   logic [DW:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q;
   logic            empty, push, pop, emit;
   state_t          state_q, ret_q;
   logic            hold_vld_q, hold_last_q, eos_q;
   logic [DW-1:0]   hold_data_q;
   logic [3:0]      gap_cnt_q;
   logic [FW-1:0]   flush_cnt_q;
   logic            vin_q, done_q;
   logic [DW-1:0]   din_q;
   logic [15:0]     sample_cnt_q;
   logic [DW-1:0]   h_q [NTAPS];

   // One-entry hold stage sits between FIFO and output so back-to-back strobes are possible.
   assign empty = (count_q == '0);
   assign push  = S_VALID && !full_q;
   assign emit  = (state_q == ST_RUN) && hold_vld_q;
   assign pop   = ((state_q == ST_RUN) || (state_q == ST_WAIT)) && !eos_q && !empty
                  && (!hold_vld_q || emit);

   assign S_READY    = !full_q;
   assign VIN        = vin_q;
   assign DIN        = din_q;
   assign DONE       = done_q;
   assign BUSY       = (state_q != ST_IDLE);
   assign SAMPLE_CNT = sample_cnt_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {S_LAST, S_DATA};
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int k = 0; k < NTAPS; k++) h_q[k] <= '0;
      end else if ((state_q == ST_IDLE) && COEF_WE && (int'(COEF_ADDR) < NTAPS)) begin
         h_q[COEF_ADDR] <= COEF_WDATA;
      end
   end

   always_comb begin
      H_FLAT = '0;
      for (int k = 0; k < NTAPS; k++) H_FLAT[k*DW +: DW] = h_q[k];
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= ST_IDLE;
         ret_q        <= ST_RUN;
         hold_vld_q   <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_data_q  <= '0;
         eos_q        <= 1'b0;
         gap_cnt_q    <= 4'd0;
         flush_cnt_q  <= '0;
         vin_q        <= 1'b0;
         din_q        <= '0;
         done_q       <= 1'b0;
         sample_cnt_q <= 16'd0;
      end else begin
         done_q <= 1'b0;
         if (pop) begin
            hold_vld_q  <= 1'b1;
            hold_data_q <= mem_q[rd_ptr_q][DW-1:0];
            hold_last_q <= mem_q[rd_ptr_q][DW];
            if (mem_q[rd_ptr_q][DW]) eos_q <= 1'b1;
         end else if (emit) begin
            hold_vld_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               vin_q <= 1'b0;
               if (START) begin
                  state_q      <= ST_RUN;
                  sample_cnt_q <= 16'd0;
                  eos_q        <= 1'b0;
               end
            end
            ST_RUN: begin
               if (hold_vld_q) begin
                  vin_q       <= 1'b1;
                  din_q       <= hold_data_q;
                  gap_cnt_q   <= GAP;
                  flush_cnt_q <= '0;
                  ret_q       <= hold_last_q ? ST_FLUSH : ST_RUN;
                  if (sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 16'd1;
                  if (GAP != 4'd0)      state_q <= ST_WAIT;
                  else if (hold_last_q) state_q <= ST_FLUSH;
                  else                  state_q <= ST_RUN;
               end else begin
                  vin_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               vin_q <= 1'b0;
               // Counter holds GAP at the strobe; leaving when it reads 1 gives exactly GAP idle cycles.
               if (gap_cnt_q <= 4'd1) state_q <= ret_q;
               else                   gap_cnt_q <= gap_cnt_q - 4'd1;
            end
            ST_FLUSH: begin
               vin_q     <= 1'b1;
               din_q     <= '0;
               gap_cnt_q <= GAP;
               ret_q     <= ST_FLUSH;
               if (flush_cnt_q == FW'(NTAPS - 2)) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q + FW'(1);
                  state_q     <= (GAP != 4'd0) ? ST_WAIT : ST_FLUSH;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               vin_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIR_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_q;

   // A cycle is an underrun only when nothing at all is ready to send.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         underrun_q <= 16'd0;
      end else if ((state_q == ST_IDLE) && START) begin
         underrun_q <= 16'd0;
      end else if ((state_q == ST_RUN) && empty && !hold_vld_q && (underrun_q != 16'hFFFF)) begin
         underrun_q <= underrun_q + 16'd1;
      end
   end

   assign UNDERRUN_CNT = underrun_q;
`endif

endmodule
